// File: rtl/decode_issue_stage.sv
// Decode/issue stage: scoreboard hazard check, stall, flush and HALT
// handling in front of a held execute-side register.
module decode_issue_stage #(
    parameter int NREGS = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       opcode_in,
    input  logic [1:0]       op_in,
    input  logic [2:0]       ReadA_in,
    input  logic [2:0]       ReadB_in,
    input  logic [2:0]       write_num_in,
    input  logic [1:0]       shift_in,
    input  logic [15:0]      sximm8_in,
    input  logic [15:0]      sximm5_in,
    input  logic [1:0]       vsel_in,
    input  logic             asel_in,
    input  logic             bsel_in,
    input  logic [1:0]       ALUop_in,
    input  logic             ex_ready,
    input  logic             flush,
    input  logic             wb_valid,
    input  logic [2:0]       wb_num,
    output logic             ex_valid,
    output logic [2:0]       ex_opcode,
    output logic [1:0]       ex_op,
    output logic [2:0]       ex_ReadA,
    output logic [2:0]       ex_ReadB,
    output logic [2:0]       ex_write_num,
    output logic [1:0]       ex_shift,
    output logic [15:0]      ex_sximm8,
    output logic [15:0]      ex_sximm5,
    output logic [1:0]       ex_vsel,
    output logic             ex_asel,
    output logic             ex_bsel,
    output logic [1:0]       ex_ALUop,
    output logic             ex_writes,
    output logic             halted,
    output logic [NREGS-1:0] pending
);

    logic             uses_a;
    logic             uses_b;
    logic             writes;
    logic             is_halt;
    logic             hazard;
    logic             advance;
    logic             accept;
    logic [NREGS-1:0] wb_mask;
    logic [NREGS-1:0] pend_eff;
    logic [NREGS-1:0] pending_nxt;

    always_comb begin
        uses_a  = (opcode_in == 3'b101 && op_in != 2'b11)
               || opcode_in == 3'b011
               || opcode_in == 3'b100;
        uses_b  = (opcode_in == 3'b110 && op_in == 2'b00)
               || opcode_in == 3'b101
               || opcode_in == 3'b100;
        writes  = opcode_in == 3'b110
               || (opcode_in == 3'b101 && op_in != 2'b01)
               || opcode_in == 3'b011;
        is_halt = opcode_in == 3'b111;
    end

    // A writeback landing this cycle already releases its register.
    always_comb begin
        wb_mask  = wb_valid ? (NREGS'(1) << wb_num) : '0;
        pend_eff = pending & ~wb_mask;
        hazard   = in_valid
                && ((uses_a && pend_eff[ReadA_in])
                 || (uses_b && pend_eff[ReadB_in]));
        advance  = !ex_valid || ex_ready;
        in_ready = advance && !hazard && !halted && !flush;
        accept   = in_valid && in_ready;
    end

    always_comb begin
        pending_nxt = pending & ~wb_mask;
        if (flush && ex_valid && ex_writes && !ex_ready)
            pending_nxt[ex_write_num] = 1'b0;
        if (accept && writes)
            pending_nxt[write_num_in] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
            halted  <= 1'b0;
        end else begin
            pending <= pending_nxt;
            if (accept && is_halt)
                halted <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid     <= 1'b0;
            ex_opcode    <= '0;
            ex_op        <= '0;
            ex_ReadA     <= '0;
            ex_ReadB     <= '0;
            ex_write_num <= '0;
            ex_shift     <= '0;
            ex_sximm8    <= '0;
            ex_sximm5    <= '0;
            ex_vsel      <= '0;
            ex_asel      <= 1'b0;
            ex_bsel      <= 1'b0;
            ex_ALUop     <= '0;
            ex_writes    <= 1'b0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (advance) begin
            ex_valid <= accept;
            if (accept) begin
                ex_opcode    <= opcode_in;
                ex_op        <= op_in;
                ex_ReadA     <= ReadA_in;
                ex_ReadB     <= ReadB_in;
                ex_write_num <= write_num_in;
                ex_shift     <= shift_in;
                ex_sximm8    <= sximm8_in;
                ex_sximm5    <= sximm5_in;
                ex_vsel      <= vsel_in;
                ex_asel      <= asel_in;
                ex_bsel      <= bsel_in;
                ex_ALUop     <= ALUop_in;
                ex_writes    <= writes;
            end
        end
    end

endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed bench for decode_issue_stage: issue, hazards, stall, flush,
// HALT and reset scenarios with hand-computed expectations.
module tb_decode_issue_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  opcode_in;
    logic [1:0]  op_in;
    logic [2:0]  ReadA_in;
    logic [2:0]  ReadB_in;
    logic [2:0]  write_num_in;
    logic [1:0]  shift_in;
    logic [15:0] sximm8_in;
    logic [15:0] sximm5_in;
    logic [1:0]  vsel_in;
    logic        asel_in;
    logic        bsel_in;
    logic [1:0]  ALUop_in;
    logic        ex_ready;
    logic        flush;
    logic        wb_valid;
    logic [2:0]  wb_num;
    logic        ex_valid;
    logic [2:0]  ex_opcode;
    logic [1:0]  ex_op;
    logic [2:0]  ex_ReadA;
    logic [2:0]  ex_ReadB;
    logic [2:0]  ex_write_num;
    logic [1:0]  ex_shift;
    logic [15:0] ex_sximm8;
    logic [15:0] ex_sximm5;
    logic [1:0]  ex_vsel;
    logic        ex_asel;
    logic        ex_bsel;
    logic [1:0]  ex_ALUop;
    logic        ex_writes;
    logic        halted;
    logic [7:0]  pending;

    int vectors = 0;
    int miscompares = 0;

    decode_issue_stage #(.NREGS(8)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode_in(opcode_in), .op_in(op_in),
        .ReadA_in(ReadA_in), .ReadB_in(ReadB_in),
        .write_num_in(write_num_in), .shift_in(shift_in),
        .sximm8_in(sximm8_in), .sximm5_in(sximm5_in),
        .vsel_in(vsel_in), .asel_in(asel_in), .bsel_in(bsel_in),
        .ALUop_in(ALUop_in), .ex_ready(ex_ready), .flush(flush),
        .wb_valid(wb_valid), .wb_num(wb_num),
        .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_op(ex_op),
        .ex_ReadA(ex_ReadA), .ex_ReadB(ex_ReadB),
        .ex_write_num(ex_write_num), .ex_shift(ex_shift),
        .ex_sximm8(ex_sximm8), .ex_sximm5(ex_sximm5),
        .ex_vsel(ex_vsel), .ex_asel(ex_asel), .ex_bsel(ex_bsel),
        .ex_ALUop(ex_ALUop), .ex_writes(ex_writes),
        .halted(halted), .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        flush    = 1'b0;
        wb_valid = 1'b0;
        wb_num   = 3'd0;
    endtask

    task automatic drive(input logic [2:0] opc, input logic [1:0] op,
                         input logic [2:0] a, input logic [2:0] b,
                         input logic [2:0] w, input logic [15:0] imm);
        in_valid     = 1'b1;
        opcode_in    = opc;
        op_in        = op;
        ReadA_in     = a;
        ReadB_in     = b;
        write_num_in = w;
        sximm8_in    = imm;
        sximm5_in    = ~imm;
        shift_in     = 2'b01;
        vsel_in      = 2'b10;
        asel_in      = 1'b0;
        bsel_in      = 1'b1;
        ALUop_in     = op;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ex_ready = 1'b0;
        idle();
        drive(3'b101, 2'b00, 3'd0, 3'd0, 3'd0, 16'h0);
        in_valid = 1'b0;
        step();
        step();
        reset = 1'b0;
        #1;
        vectors++; if (ex_valid !== 1'b0) begin miscompares++; $display("FAIL reset_ex_valid got=%0h exp=0", ex_valid); end
        vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL reset_halted got=%0h exp=0", halted); end
        vectors++; if (pending !== 8'h00) begin miscompares++; $display("FAIL reset_pending got=%h exp=00", pending); end
        vectors++; if (ex_write_num !== 3'd0) begin miscompares++; $display("FAIL reset_ex_write_num got=%0d exp=0", ex_write_num); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got=%0h exp=1", in_ready); end
    endtask

    task automatic test_issue();
        ex_ready = 1'b1;
        drive(3'b101, 2'b00, 3'd1, 3'd2, 3'd3, 16'h00a5);
        #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL issue_in_ready got=%0h exp=1", in_ready); end
        step();
        idle();
        #1;
        vectors++; if (ex_valid !== 1'b1) begin miscompares++; $display("FAIL issue_ex_valid got=%0h exp=1", ex_valid); end
        vectors++; if (ex_write_num !== 3'd3) begin miscompares++; $display("FAIL issue_ex_write_num got=%0d exp=3", ex_write_num); end
        vectors++; if (pending !== 8'h08) begin miscompares++; $display("FAIL issue_pending got=%h exp=08", pending); end
        vectors++; if (ex_ReadA !== 3'd1 || ex_ReadB !== 3'd2) begin miscompares++; $display("FAIL issue_ex_reads got=%0d/%0d exp=1/2", ex_ReadA, ex_ReadB); end
        vectors++; if (ex_sximm8 !== 16'h00a5 || ex_sximm5 !== 16'hff5a) begin miscompares++; $display("FAIL issue_ex_imm got=%h/%h exp=00a5/ff5a", ex_sximm8, ex_sximm5); end
        vectors++; if (ex_writes !== 1'b1) begin miscompares++; $display("FAIL issue_ex_writes got=%0h exp=1", ex_writes); end
    endtask

    task automatic test_hazard();
        drive(3'b101, 2'b10, 3'd4, 3'd3, 3'd6, 16'h0001);
        #1;
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL hazard_in_ready0 got=%0h exp=0", in_ready); end
        step();
        vectors++; if (ex_valid !== 1'b0) begin miscompares++; $display("FAIL hazard_bubble got=%0h exp=0", ex_valid); end
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL hazard_in_ready1 got=%0h exp=0", in_ready); end
        wb_valid = 1'b1;
        wb_num = 3'd3;
        #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL hazard_wb_release got=%0h exp=1", in_ready); end
        step();
        idle();
        #1;
        vectors++; if (pending !== 8'h40) begin miscompares++; $display("FAIL hazard_pending got=%h exp=40", pending); end
        vectors++; if (ex_valid !== 1'b1 || ex_write_num !== 3'd6) begin miscompares++; $display("FAIL hazard_ex got=%0h/%0d exp=1/6", ex_valid, ex_write_num); end
        wb_valid = 1'b1;
        wb_num = 3'd6;
        step();
        wb_num = 3'd0;
        step();
        idle();
        vectors++; if (pending !== 8'h00) begin miscompares++; $display("FAIL hazard_wb_nonpending got=%h exp=00", pending); end
    endtask

    task automatic test_stall();
        ex_ready = 1'b0;
        drive(3'b110, 2'b10, 3'd0, 3'd0, 3'd1, 16'h0011);
        step();
        vectors++; if (ex_valid !== 1'b1 || pending !== 8'h02) begin miscompares++; $display("FAIL stall_load got=%0h/%h exp=1/02", ex_valid, pending); end
        drive(3'b101, 2'b11, 3'd7, 3'd0, 3'd2, 16'h0022);
        #1;
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL stall_in_ready got=%0h exp=0", in_ready); end
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++; if (ex_valid !== 1'b1 || ex_write_num !== 3'd1 || ex_sximm8 !== 16'h0011 || in_ready !== 1'b0) begin miscompares++; $display("FAIL stall_hold%0d got=%0h/%0d/%h/%0h exp=1/1/0011/0", i, ex_valid, ex_write_num, ex_sximm8, in_ready); end
        end
        ex_ready = 1'b1;
        #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL stall_release got=%0h exp=1", in_ready); end
        step();
        idle();
        #1;
        vectors++; if (ex_write_num !== 3'd2 || ex_opcode !== 3'b101 || ex_op !== 2'b11) begin miscompares++; $display("FAIL stall_next got=%0d/%b/%b exp=2/101/11", ex_write_num, ex_opcode, ex_op); end
        vectors++; if (pending !== 8'h06) begin miscompares++; $display("FAIL stall_pending got=%h exp=06", pending); end
        wb_valid = 1'b1;
        wb_num = 3'd1;
        step();
        wb_num = 3'd2;
        step();
        idle();
        vectors++; if (pending !== 8'h00 || ex_valid !== 1'b0) begin miscompares++; $display("FAIL stall_drain got=%h/%0h exp=00/0", pending, ex_valid); end
    endtask

    task automatic test_flush();
        ex_ready = 1'b0;
        drive(3'b110, 2'b10, 3'd0, 3'd0, 3'd5, 16'h0055);
        step();
        vectors++; if (ex_valid !== 1'b1 || pending !== 8'h20) begin miscompares++; $display("FAIL flush_load got=%0h/%h exp=1/20", ex_valid, pending); end
        drive(3'b101, 2'b01, 3'd0, 3'd0, 3'd0, 16'h0);
        flush = 1'b1;
        #1;
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL flush_in_ready got=%0h exp=0", in_ready); end
        step();
        idle();
        #1;
        vectors++; if (ex_valid !== 1'b0 || pending !== 8'h00) begin miscompares++; $display("FAIL flush_cancel got=%0h/%h exp=0/00", ex_valid, pending); end
        ex_ready = 1'b1;
        drive(3'b110, 2'b10, 3'd0, 3'd0, 3'd5, 16'h0055);
        step();
        drive(3'b101, 2'b01, 3'd0, 3'd0, 3'd0, 16'h0);
        flush = 1'b1;
        #1;
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL flush_rdy_in_ready got=%0h exp=0", in_ready); end
        step();
        idle();
        #1;
        vectors++; if (ex_valid !== 1'b0 || pending !== 8'h20) begin miscompares++; $display("FAIL flush_consumed got=%0h/%h exp=0/20", ex_valid, pending); end
        wb_valid = 1'b1;
        wb_num = 3'd5;
        step();
        idle();
        drive(3'b101, 2'b01, 3'd4, 3'd4, 3'd7, 16'h0);
        step();
        idle();
        #1;
        vectors++; if (ex_valid !== 1'b1 || ex_writes !== 1'b0 || pending !== 8'h00) begin miscompares++; $display("FAIL cmp_nowrite got=%0h/%0h/%h exp=1/0/00", ex_valid, ex_writes, pending); end
        step();
    endtask

    task automatic test_halt();
        int held;
        ex_ready = 1'b1;
        drive(3'b110, 2'b10, 3'd0, 3'd0, 3'd7, 16'h0077);
        step();
        drive(3'b111, 2'b00, 3'd0, 3'd0, 3'd0, 16'h0);
        #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL halt_accept got=%0h exp=1", in_ready); end
        step();
        vectors++; if (halted !== 1'b1 || ex_opcode !== 3'b111 || ex_valid !== 1'b1) begin miscompares++; $display("FAIL halt_enter got=%0h/%b/%0h exp=1/111/1", halted, ex_opcode, ex_valid); end
        vectors++; if (pending !== 8'h80) begin miscompares++; $display("FAIL halt_pending got=%h exp=80", pending); end
        drive(3'b101, 2'b00, 3'd1, 3'd2, 3'd3, 16'h0);
        held = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (in_ready === 1'b0) held++;
            step();
        end
        vectors++; if (held !== 10) begin miscompares++; $display("FAIL halt_hold got=%0d exp=10", held); end
        vectors++; if (halted !== 1'b1 || ex_valid !== 1'b0) begin miscompares++; $display("FAIL halt_sticky got=%0h/%0h exp=1/0", halted, ex_valid); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        idle();
        #1;
        vectors++; if (halted !== 1'b0 || pending !== 8'h00 || ex_valid !== 1'b0) begin miscompares++; $display("FAIL halt_reset got=%0h/%h/%0h exp=0/00/0", halted, pending, ex_valid); end
    endtask

    task automatic test_reset_mid_stall();
        ex_ready = 1'b1;
        drive(3'b110, 2'b10, 3'd0, 3'd0, 3'd2, 16'h0002);
        step();
        drive(3'b110, 2'b10, 3'd0, 3'd0, 3'd3, 16'h0003);
        step();
        vectors++; if (pending !== 8'h0c) begin miscompares++; $display("FAIL mid_pending got=%h exp=0c", pending); end
        drive(3'b101, 2'b00, 3'd2, 3'd3, 3'd4, 16'h0044);
        #1;
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL mid_stall got=%0h exp=0", in_ready); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        vectors++; if (pending !== 8'h00 || ex_valid !== 1'b0 || halted !== 1'b0) begin miscompares++; $display("FAIL mid_reset got=%h/%0h/%0h exp=00/0/0", pending, ex_valid, halted); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL mid_in_ready got=%0h exp=1", in_ready); end
        step();
        idle();
        #1;
        vectors++; if (ex_valid !== 1'b1 || ex_ReadA !== 3'd2 || pending !== 8'h10) begin miscompares++; $display("FAIL mid_issue got=%0h/%0d/%h exp=1/2/10", ex_valid, ex_ReadA, pending); end
    endtask

    initial begin
        test_reset();
        test_issue();
        test_hazard();
        test_stall();
        test_flush();
        test_halt();
        test_reset_mid_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/decode_issue_stage.md
Name: decode_issue_stage

Overview:
- Consumer end of the fetch/decode pipeline register. Takes the decoded instruction fields, checks them against a register-write scoreboard, and issues them into a held execute-side register.
- Generates the upstream stall (in_ready) and handles flush (taken branch) and HALT.
- Sits between the fetch/decode register outputs and the execute datapath. Writeback reports completed register writes back into it.

Parameters:
- NREGS, 8, number of architectural registers tracked by the scoreboard (register index width fixed at 3).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  decoded instruction present on the *_in fields.
- in_ready  out  1  combinational: the instruction is accepted this cycle.
- opcode_in  in  3  decoded opcode.
- op_in  in  2  decoded sub-op.
- ReadA_in  in  3  source register A (Rn).
- ReadB_in  in  3  source register B (Rm, or Rd for STR).
- write_num_in  in  3  destination register.
- shift_in  in  2  shift control.
- sximm8_in  in  16  sign-extended imm8.
- sximm5_in  in  16  sign-extended imm5.
- vsel_in  in  2  writeback mux select.
- asel_in, bsel_in  in  1 each  ALU operand selects.
- ALUop_in  in  2  ALU operation.
- ex_ready  in  1  execute consumes ex_* this cycle.
- flush  in  1  cancel the unconsumed ex instruction and the input instruction.
- wb_valid  in  1  writeback completes a register write.
- wb_num  in  3  register written back.
- ex_valid  out  1  ex_* holds a live instruction.
- ex_opcode, ex_op, ex_ReadA, ex_ReadB, ex_write_num, ex_shift, ex_sximm8, ex_sximm5, ex_vsel, ex_asel, ex_bsel, ex_ALUop  out  same widths as the inputs  registered payload.
- ex_writes  out  1  the ex instruction writes ex_write_num.
- halted  out  1  a HALT has been accepted.
- pending  out  8  scoreboard, bit i set means register i has a write in flight.

Behaviour:
Reset (synchronous, active-high):
- All outputs and the scoreboard go to 0.
- Reset overrides flush, wb and accept in the same cycle.

Internal decode of the input instruction:
- uses_a = (opcode 101 and op != 11) or opcode 011 or opcode 100.
- uses_b = (opcode 110 and op 00) or opcode 101 or opcode 100.
- writes = opcode 110 or (opcode 101 and op != 01) or opcode 011.
- is_halt = opcode 111.

Hazard check:
- pend_eff = pending AND NOT onehot(wb_num) when wb_valid, otherwise pending. A same-cycle writeback releases the hazard.
- hazard = (uses_a and pend_eff[ReadA_in]) or (uses_b and pend_eff[ReadB_in]).

Handshake:
- advance = NOT ex_valid OR ex_ready.
- in_ready = advance AND NOT hazard AND NOT halted AND NOT flush.
- accept = in_valid AND in_ready.

Ex register, on each rising edge with no reset:
- If flush: ex_valid <= 0.
- Else if advance: ex_valid <= accept, and the payload and ex_writes are loaded from the inputs when accept is 1.
- Else: everything holds.
- Payload is not cleared on a bubble; only ex_valid qualifies it.
- Latency is 1 cycle from accept to ex_valid.

Scoreboard next state:
- Start from pending.
- Clear bit wb_num if wb_valid.
- Clear bit ex_write_num if flush and ex_valid and ex_writes and NOT ex_ready. The cancelled write never retires.
- Set bit write_num_in if accept and writes. Set wins over clear on the same bit in the same cycle.

HALT:
- Accepting is_halt sets halted <= 1 on the next edge.
- The HALT itself enters ex normally.
- halted stays 1 and in_ready stays 0 until reset.

Boundary cases:
- flush with ex_ready=1 in the same cycle: the ex instruction is consumed (not cancelled), ex_valid goes to 0, and its pending bit stays set.
- wb_valid for a register not pending: no effect.
- in_valid=0: no scoreboard set, and no hazard is reported on in_ready.

Test Plan:
1. After reset, issue ADD (101/00, ReadA=1, ReadB=2, write 3) with ex_ready=1.
   -> in_ready=1; next cycle ex_valid=1, ex_write_num=3, pending=8'h08.
2. With pending[3]=1, present AND reading ReadB=3.
   -> in_ready=0 while the hazard holds.
   -> Assert wb_valid with wb_num=3 in that cycle: in_ready=1 the same cycle; pending bit3 re-set only if the new instruction writes r3.
3. Hold ex_ready=0 with ex_valid=1 and feed a new instruction.
   -> in_ready=0 and ex_* held for 3 cycles.
   -> ex_ready=1: new instruction loads on the next edge.
4. MOV imm to r5 sits in ex (ex_ready=0); assert flush.
   -> ex_valid=0 next cycle, pending[5] cleared, in_ready=0 during the flush cycle.
5. Accept HALT (111).
   -> halted=1 next cycle; in_ready stays 0 with in_valid=1 for 10 cycles.
   -> reset: halted=0, pending=0, ex_valid=0.
6. Assert reset mid-stall with pending=8'h0C.
   -> Next cycle all outputs 0; a subsequent ADD reading r2/r3 is accepted immediately.
